// File: rtl/kamikaze_ahb_sram.sv
// AHB-Lite responder wrapping a word-organised single-port SRAM.
// Byte/half/word writes, fixed wait states, two-cycle ERROR, same-word read forwarding.
module kamikaze_ahb_sram #(
    parameter int          ADDR_BITS   = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);
    localparam int MEM_WORDS = 2 ** ADDR_BITS;

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   idx_q, idx_d;
    logic [3:0]             lanes_q, lanes_d;
    logic                   write_q, write_d;
    logic [31:0]            hrdata_q, hrdata_d;

    logic [31:0]            mem [MEM_WORDS];

    logic                   accept;
    logic                   in_range;
    logic                   illegal;
    logic [3:0]             acc_lanes;
    logic [ADDR_BITS-1:0]   acc_idx;
    logic                   commit;
    logic                   rd_en;
    logic [ADDR_BITS-1:0]   rd_idx;
    logic [31:0]            rd_word;
    logic                   unused_ok;

    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

    assign accept   = HSEL & HREADY & HTRANS[1];
    assign acc_idx  = HADDR[ADDR_BITS+1:2];
    assign in_range = (HADDR[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);
    assign commit   = (state_q == ST_DATA) && write_q;

    always_comb begin
        acc_lanes = 4'b0000;
        illegal   = !in_range;
        case (HSIZE)
            3'd0: acc_lanes = 4'b0001 << HADDR[1:0];
            3'd1: begin
                acc_lanes = HADDR[1] ? 4'b1100 : 4'b0011;
                if (HADDR[0]) illegal = 1'b1;
            end
            3'd2: begin
                acc_lanes = 4'b1111;
                if (HADDR[1:0] != 2'b00) illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lanes_d = lanes_q;
        write_d = write_q;
        rd_en   = 1'b0;
        rd_idx  = idx_q;
        case (state_q)
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_DATA;
                    rd_en   = !write_q;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                // IDLE, DATA and ERR2 all present HREADYOUT=1, so a new phase may land here.
                state_d = ST_IDLE;
                write_d = 1'b0;
                if (accept) begin
                    idx_d   = acc_idx;
                    lanes_d = acc_lanes;
                    if (illegal) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_STATES);
                        write_d = HWRITE;
                    end else begin
                        state_d = ST_DATA;
                        write_d = HWRITE;
                        rd_en   = !HWRITE;
                        rd_idx  = acc_idx;
                    end
                end
            end
        endcase
    end

    // A read issued while a write to the same word is in its data phase sees the new lanes.
    always_comb begin
        rd_word = mem[rd_idx];
        if (commit && (idx_q == rd_idx)) begin
            for (int i = 0; i < 4; i++) begin
                if (lanes_q[i]) rd_word[8*i +: 8] = HWDATA[8*i +: 8];
            end
        end
        hrdata_d = hrdata_q;
        if (rd_en) hrdata_d = rd_word;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            idx_q    <= '0;
            lanes_q  <= 4'b0000;
            write_q  <= 1'b0;
            hrdata_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            lanes_q  <= lanes_d;
            write_q  <= write_d;
            hrdata_q <= hrdata_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (lanes_q[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    assign HREADYOUT = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
    assign HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    assign HRDATA    = (write_q || HRESP) ? 32'h0 : hrdata_q;

endmodule

// File: tb/tb_kamikaze_ahb_sram.sv
// Directed bench: three SRAM instances with 0, 2 and 3 wait states on a shared master bus.
module tb_kamikaze_ahb_sram;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  sel = 3'b000;
    logic [31:0] haddr = 32'h0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd2;
    logic [31:0] hwdata = 32'h0;
    logic [2:0]  ready_o;
    logic [2:0]  resp_o;
    logic [31:0] rdata_o [3];
    int          cur = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        kamikaze_ahb_sram #(
            .ADDR_BITS   (12),
            .BASE_ADDR   (32'h0000_0000),
            .WAIT_STATES ((g == 0) ? 0 : (g == 1) ? 2 : 3)
        ) u_dut (
            .clk_i     (clk),
            .rst_i     (rst),
            .HSEL      (sel[g]),
            .HADDR     (haddr),
            .HTRANS    (htrans),
            .HWRITE    (hwrite),
            .HSIZE     (hsize),
            .HBURST    (3'b000),
            .HPROT     (4'b0011),
            .HMASTLOCK (1'b0),
            .HWDATA    (hwdata),
            .HREADY    (ready_o[g]),
            .HREADYOUT (ready_o[g]),
            .HRESP     (resp_o[g]),
            .HRDATA    (rdata_o[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ph(input logic [31:0] a, input logic w, input logic [2:0] sz);
        haddr  = a;
        hwrite = w;
        hsize  = sz;
        htrans = 2'b10;
    endtask

    task automatic idle();
        htrans = 2'b00;
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d, input int n);
        ph(a, 1'b1, 3'd2);
        cyc();
        hwdata = d;
        idle();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_wait"}, 32'(ready_o[cur]), 32'd0);
            cyc();
        end
        chk({tag, "_ready"}, 32'(ready_o[cur]), 32'd1);
        chk({tag, "_rdata0"}, rdata_o[cur], 32'h0);
        cyc();
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input int n, input logic [31:0] exp);
        ph(a, 1'b0, 3'd2);
        cyc();
        idle();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_wait"}, 32'(ready_o[cur]), 32'd0);
            cyc();
        end
        chk({tag, "_ready"}, 32'(ready_o[cur]), 32'd1);
        chk({tag, "_resp"}, 32'(resp_o[cur]), 32'd0);
        chk({tag, "_data"}, rdata_o[cur], exp);
    endtask

    task automatic err(input string tag, input logic [31:0] a, input logic w, input logic [2:0] sz);
        ph(a, w, sz);
        cyc();
        hwdata = 32'hFFFF_FFFF;
        idle();
        chk({tag, "_e1_ready"}, 32'(ready_o[cur]), 32'd0);
        chk({tag, "_e1_resp"}, 32'(resp_o[cur]), 32'd1);
        chk({tag, "_e1_rdata"}, rdata_o[cur], 32'h0);
        cyc();
        chk({tag, "_e2_ready"}, 32'(ready_o[cur]), 32'd1);
        chk({tag, "_e2_resp"}, 32'(resp_o[cur]), 32'd1);
        cyc();
        chk({tag, "_after_resp"}, 32'(resp_o[cur]), 32'd0);
    endtask

    initial begin
        cyc();
        cyc();
        chk("rst_ready", 32'(ready_o[0]), 32'd1);
        chk("rst_resp", 32'(resp_o[0]), 32'd0);
        chk("rst_rdata", rdata_o[0], 32'h0);
        rst = 1'b0;
        cyc();

        // zero wait states
        cur = 0;
        sel = 3'b001;
        wr("w0", 32'h0, 32'hDEAD_BEEF, 0);
        rd("r0", 32'h0, 0, 32'hDEAD_BEEF);

        ph(32'h4, 1'b1, 3'd2);
        cyc();
        hwdata = 32'h1122_3344;
        ph(32'h5, 1'b1, 3'd0);
        cyc();
        hwdata = 32'h0000_AB00;
        ph(32'h4, 1'b0, 3'd2);
        cyc();
        chk("byte_fwd", rdata_o[0], 32'h1122_AB44);
        chk("byte_fwd_ready", 32'(ready_o[0]), 32'd1);
        ph(32'h6, 1'b1, 3'd1);
        cyc();
        chk("half_wphase_rdata", rdata_o[0], 32'h0);
        hwdata = 32'h5566_0000;
        ph(32'h4, 1'b0, 3'd2);
        cyc();
        idle();
        chk("half_fwd", rdata_o[0], 32'h5566_AB44);
        cyc();
        rd("r4_mem", 32'h4, 0, 32'h5566_AB44);

        ph(32'h8, 1'b1, 3'd2);
        cyc();
        hwdata = 32'hCAFE_F00D;
        ph(32'h8, 1'b0, 3'd2);
        cyc();
        chk("pipe_r8", rdata_o[0], 32'hCAFE_F00D);
        chk("pipe_r8_ready", 32'(ready_o[0]), 32'd1);
        ph(32'h8, 1'b1, 3'd2);
        cyc();
        hwdata = 32'h0102_0304;
        ph(32'h4, 1'b0, 3'd2);
        cyc();
        idle();
        chk("other_word_nofwd", rdata_o[0], 32'h5566_AB44);
        cyc();
        rd("r8_mem", 32'h8, 0, 32'h0102_0304);

        err("e_misalign_word", 32'h2, 1'b0, 3'd2);
        err("e_out_range", 32'h4000, 1'b0, 3'd2);
        err("e_wr_out_range", 32'h4000, 1'b1, 3'd2);
        err("e_wr_half_odd", 32'h1, 1'b1, 3'd1);
        err("e_wr_size3", 32'h4, 1'b1, 3'd3);
        rd("r0_after_err", 32'h0, 0, 32'hDEAD_BEEF);
        rd("r4_after_err", 32'h4, 0, 32'h5566_AB44);
        idle();
        cyc();

        // two wait states, held NONSEQ during the wait
        cur = 1;
        sel = 3'b010;
        wr("w1_0", 32'h0, 32'h0000_1111, 2);
        wr("w1_4", 32'h4, 32'h2222_3333, 2);
        ph(32'h0, 1'b0, 3'd2);
        cyc();
        ph(32'h4, 1'b0, 3'd2);
        chk("ws2_wait1", 32'(ready_o[1]), 32'd0);
        cyc();
        chk("ws2_wait2", 32'(ready_o[1]), 32'd0);
        cyc();
        chk("ws2_data_ready", 32'(ready_o[1]), 32'd1);
        chk("ws2_data", rdata_o[1], 32'h0000_1111);
        cyc();
        idle();
        chk("ws2_held_wait1", 32'(ready_o[1]), 32'd0);
        cyc();
        chk("ws2_held_wait2", 32'(ready_o[1]), 32'd0);
        cyc();
        chk("ws2_held_ready", 32'(ready_o[1]), 32'd1);
        chk("ws2_held_data", rdata_o[1], 32'h2222_3333);
        cyc();

        // three wait states, reset mid-write
        cur = 2;
        sel = 3'b100;
        wr("w2_c", 32'hC, 32'h0F0F_0F0F, 3);
        rd("r2_c", 32'hC, 3, 32'h0F0F_0F0F);
        ph(32'hC, 1'b1, 3'd2);
        cyc();
        hwdata = 32'h1234_5678;
        idle();
        chk("ws3_wr_wait1", 32'(ready_o[2]), 32'd0);
        cyc();
        chk("ws3_wr_wait2", 32'(ready_o[2]), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(ready_o[2]), 32'd1);
        chk("mid_rst_resp", 32'(resp_o[2]), 32'd0);
        chk("mid_rst_rdata", rdata_o[2], 32'h0);
        cyc();
        rst = 1'b0;
        cyc();
        cyc();
        rd("r2_c_old", 32'hC, 3, 32'h0F0F_0F0F);
        idle();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/kamikaze_ahb_sram.md
Name: kamikaze_ahb_sram

Overview:
AHB-Lite slave (responder) wrapping a single-port word-organised SRAM. It is the memory end of the bus driven by the core's fetch and load/store masters. It serves instruction fetch and data traffic, with byte/halfword/word writes, a configurable number of wait states and the standard two-cycle ERROR response. Reads are pipelined: address phase in cycle N, data phase in cycle N+1+WAIT_STATES.

Parameters:
ADDR_BITS, 12, log2 of memory depth in 32-bit words (MEM_WORDS = 2**ADDR_BITS)
BASE_ADDR, 32'h0000_0000, byte base address of the window; must be aligned to 4*MEM_WORDS
WAIT_STATES, 0, HREADYOUT-low cycles inserted in every OKAY data phase (0..15)

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  asynchronous, active-high reset
HSEL  in  1  slave select from decoder
HADDR  in  32  byte address (address phase)
HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
HWRITE  in  1  1 = write
HSIZE  in  3  000 byte, 001 half, 010 word; others illegal
HBURST  in  3  ignored (every beat decoded standalone)
HPROT  in  4  ignored
HMASTLOCK  in  1  ignored
HWDATA  in  32  write data (data phase)
HREADY  in  1  bus-level ready (muxed HREADYOUT of current data-phase slave)
HREADYOUT  out  1  this slave's ready
HRESP  out  1  0 OKAY, 1 ERROR
HRDATA  out  32  read data, valid when HREADYOUT=1, HRESP=0, read data phase

Behaviour:
- Reset (async, rst_i=1): HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, wait counter 0, pending write discarded. Memory contents are not reset. Reset mid-transfer aborts it; nothing is committed.
- Accept: an address phase is sampled on an edge where HSEL & HREADY & HTRANS[1]. IDLE/BUSY, or HSEL=0, give a zero-wait OKAY and no state change.
- Decode at accept:
  - word index = HADDR[ADDR_BITS+1:2].
  - in range iff HADDR[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2].
  - Lanes: size 0 gives lane HADDR[1:0]; size 1 gives lanes {HADDR[1],1},{HADDR[1],0}; size 2 gives all four.
  - Illegal: size>2, size 1 with HADDR[0]=1, size 2 with HADDR[1:0]!=0, or out of range.
- States: IDLE, WAIT, DATA, ERR1, ERR2.
  - Legal accept: go to WAIT with counter=WAIT_STATES if WAIT_STATES>0, else to DATA.
  - WAIT: HREADYOUT=0, decrement counter; at 1, go to DATA.
  - DATA: HREADYOUT=1, HRESP=0.
    - Read: HRDATA = full stored word; the master selects lanes.
    - Write: HWDATA lanes are committed to memory at the end of this cycle; HRDATA=0.
    - From DATA, go to the next accepted phase's state, or to IDLE.
  - Illegal accept: ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), then as from DATA. No memory write; HRDATA=0.
- Read path: the SRAM read is issued on the accept edge, or on the last WAIT edge, so data is registered into HRDATA for the DATA cycle.
- Hazard (WAIT_STATES=0): a read accepted in the same cycle as a write DATA to the same word returns the newly written lanes merged over the old word (forwarding). Reads of other words are unaffected.
- New address phases are only accepted when HREADY=1. During own WAIT/ERR1 cycles HREADY=0, so none are accepted.
- Back-to-back NONSEQ/SEQ with WAIT_STATES=0 sustain one transfer per cycle.
- HRDATA holds its last value outside read DATA cycles. Zero is driven on reset and in write/error data phases.

Test Plan:
- WAIT_STATES=0: write word 0x0 = 32'hDEADBEEF, then read 0x0 -> HRDATA=32'hDEADBEEF in the read data phase; HREADYOUT never 0; HRESP=0.
- Word 0x4 holds 32'h11223344; byte write HADDR=0x5, HWDATA=32'h0000AB00 -> readback 32'h1122AB44. Half write HADDR=0x6, HWDATA=32'h55660000 -> readback 32'h5566AB44.
- Pipelined write 0x8 = 32'hCAFEF00D, immediately followed by read 0x8 (address phase during write data phase) -> HRDATA=32'hCAFEF00D next cycle.
- WAIT_STATES=2: read 0x0 -> HREADYOUT=0 for exactly 2 cycles, then 1 with HRDATA valid. An HTRANS=NONSEQ held by the master during the wait is accepted only after the data cycle.
- Word read HADDR=0x2, then read HADDR=BASE_ADDR+4*MEM_WORDS -> each gives HREADYOUT 0 then 1 with HRESP=1 on both cycles; memory unchanged (readback of prior data).
- WAIT_STATES=3 write 0xC = 32'h12345678; assert rst_i during the 2nd wait cycle -> HREADYOUT=1, HRESP=0, HRDATA=0 immediately; later read 0xC returns the old value.
